// File: rtl/muxn_pkg.sv
// Shared types and helpers for the registered N-input channel multiplexer.
package muxn_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } obuf_state_t;

    // Modulo increment that wraps correctly for non-power-of-two channel counts.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotated priority encoder: first set request at or after ptr, modulo N_IN.
module rr_pick #(
    parameter  int N_IN  = 4,
    localparam int SEL_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] grant,
    output logic             grant_ok
);

    logic [SEL_W:0] w_idx;

    always_comb begin
        grant    = '0;
        grant_ok = 1'b0;
        w_idx    = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            w_idx = {1'b0, ptr} + (SEL_W+1)'(k);
            if (w_idx >= (SEL_W+1)'(N_IN)) begin
                w_idx = w_idx - (SEL_W+1)'(N_IN);
            end
            if (!grant_ok && req[w_idx[SEL_W-1:0]]) begin
                grant    = w_idx[SEL_W-1:0];
                grant_ok = 1'b1;
            end
        end
    end

endmodule

// File: rtl/muxn_rr.sv
// Registered N-input valid/ready channel mux with fixed-select or round-robin
// arbitration; a one-entry output register reports the source channel.
module muxn_rr
    import muxn_pkg::*;
#(
    parameter  int IN_WIDTH = 7,
    parameter  int N_IN     = 4,
    localparam int SEL_W    = $clog2(N_IN)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mode,
    input  logic [SEL_W-1:0]              sel,
    input  logic [N_IN-1:0][IN_WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]               in_valid,
    output logic [N_IN-1:0]               in_ready,
    output logic [IN_WIDTH-1:0]           out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SEL_W-1:0]              out_src
);

    obuf_state_t          r_state;
    obuf_state_t          w_state_nxt;
    logic [IN_WIDTH-1:0]  r_data;
    logic [SEL_W-1:0]     r_src;
    logic [SEL_W-1:0]     r_ptr;

    mux_mode_t            w_mode;
    logic                 w_load_en;
    logic [SEL_W-1:0]     w_rr_grant;
    logic                 w_rr_ok;
    logic                 w_sel_in_range;
    logic                 w_fix_ok;
    logic [SEL_W-1:0]     w_grant;
    logic                 w_grant_ok;
    logic                 w_xfer;

    assign w_mode = mux_mode_t'(mode);

    rr_pick #(
        .N_IN (N_IN)
    ) u_rr_pick (
        .req      (in_valid),
        .ptr      (r_ptr),
        .grant    (w_rr_grant),
        .grant_ok (w_rr_ok)
    );

    // An out-of-range sel never serves a channel, even if the index aliases.
    assign w_sel_in_range = (32'(sel) < N_IN);
    assign w_fix_ok       = w_sel_in_range && in_valid[sel];

    always_comb begin
        w_grant    = sel;
        w_grant_ok = w_fix_ok;
        if (w_mode == MODE_RR) begin
            w_grant    = w_rr_grant;
            w_grant_ok = w_rr_ok;
        end
    end

    assign w_load_en = (r_state == EMPTY) || out_ready;
    assign w_xfer    = rst_n && w_load_en && w_grant_ok;

    always_comb begin
        in_ready = '0;
        if (w_xfer) begin
            in_ready[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer) begin
            w_state_nxt = FULL;
        end else if (out_ready && (r_state == FULL)) begin
            w_state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_src  <= '0;
            r_ptr  <= '0;
        end else if (w_xfer) begin
            r_data <= in_data[w_grant];
            r_src  <= w_grant;
            if (w_mode == MODE_RR) begin
                r_ptr <= SEL_W'(wrap_inc(32'(w_grant), N_IN));
            end
        end
    end

    assign out_valid = (r_state == FULL);
    assign out_data  = r_data;
    assign out_src   = r_src;

endmodule

// File: tb/tb_muxn_rr.sv
// Directed bench for muxn_rr: a channel-scan model checks every cycle, and
// literal expectations pin the headline scenarios (N_IN=4 and N_IN=3).
module tb_muxn_rr;

    logic             clk = 1'b0;
    logic             rst_n;

    logic             mode;
    logic [1:0]       sel;
    logic [3:0][6:0]  in_data;
    logic [3:0]       in_valid;
    logic [3:0]       in_ready;
    logic [6:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_src;

    logic             mode3;
    logic [1:0]       sel3;
    logic [2:0][6:0]  in_data3;
    logic [2:0]       in_valid3;
    logic [2:0]       in_ready3;
    logic [6:0]       out_data3;
    logic             out_valid3;
    logic             out_ready3;
    logic [1:0]       out_src3;

    int n_err = 0;
    int n_chk = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    muxn_rr #(.IN_WIDTH(7), .N_IN(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_src(out_src)
    );

    muxn_rr #(.IN_WIDTH(7), .N_IN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_src(out_src3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Which channel the rules pick for N_IN=4, or -1 when none is served.
    function automatic int choose(input logic md, input logic [1:0] s,
                                  input logic [3:0] v, input int p);
        if (!md) begin
            if (int'(s) < 4 && v[s]) return int'(s);
            return -1;
        end
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    logic        m_valid;
    logic [6:0]  m_data;
    int          m_src;
    int          m_ptr;
    int          e_g;
    logic [3:0]  e_ready;

    always_comb begin
        e_g     = choose(mode, sel, in_valid, m_ptr);
        e_ready = 4'b0000;
        if (rst_n === 1'b1 && (!m_valid || out_ready) && e_g >= 0) begin
            e_ready = 4'(1 << e_g);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_src   <= 0;
            m_ptr   <= 0;
        end else if ((!m_valid || out_ready) && e_g >= 0) begin
            m_valid <= 1'b1;
            m_data  <= in_data[e_g];
            m_src   <= e_g;
            if (mode) m_ptr <= (e_g + 1) % 4;
        end else if (out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_in_ready", 32'(in_ready), 32'(e_ready));
            chk("model_out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("model_out_data", 32'(out_data), 32'(m_data));
                chk("model_out_src", 32'(out_src), 32'(m_src));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; sel = 2'd0; in_data = '0; in_valid = '0; out_ready = 1'b0;
        mode3 = 1'b0; sel3 = 2'd0; in_data3 = '0; in_valid3 = '0; out_ready3 = 1'b0;
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Fixed select on channel 2, one word per cycle.
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        in_data[0] = 7'h10; in_data[1] = 7'h21; in_data[2] = 7'h55; in_data[3] = 7'h33;
        #1 chk("fix_in_ready", 32'(in_ready), 32'h4);
        tick();
        chk("fix_data0", 32'(out_data), 32'h55);
        chk("fix_src0", 32'(out_src), 32'd2);
        in_data[2] = 7'h56;
        tick();
        chk("fix_data1", 32'(out_data), 32'h56);
        chk("fix_valid1", 32'(out_valid), 32'd1);

        // Round-robin fairness.
        mode = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_all_src", 32'(out_src), 32'(k % 4));
        end
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_13_src", 32'(out_src), (k % 2 == 0) ? 32'd1 : 32'd3);
        end

        // Backpressure: hold 7'h12, then pop and load in the same edge.
        in_valid = 4'b0001; in_data[0] = 7'h12;
        tick();
        chk("bp_load", 32'(out_data), 32'h12);
        out_ready = 1'b0; in_valid = 4'b1111; in_data[1] = 7'h2A;
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
            chk("bp_hold_data", 32'(out_data), 32'h12);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(in_ready), 32'h2);
        tick();
        chk("bp_nobubble_data", 32'(out_data), 32'h2A);
        chk("bp_nobubble_src", 32'(out_src), 32'd1);

        // Mode switch with ptr = 2; ptr must survive the FIXED interval.
        mode = 1'b0; sel = 2'd0;
        tick();
        chk("ms_fix_src_a", 32'(out_src), 32'd0);
        tick();
        chk("ms_fix_src_b", 32'(out_src), 32'd0);
        mode = 1'b1; in_valid = 4'b1011;
        #1 chk("ms_rr_ready", 32'(in_ready), 32'h8);
        tick();
        chk("ms_rr_src", 32'(out_src), 32'd3);

        // sel change while stalled is ignored until the register can load.
        mode = 1'b0; sel = 2'd1; out_ready = 1'b0; in_valid = 4'b1111;
        tick();
        chk("stall_sel_src", 32'(out_src), 32'd3);
        out_ready = 1'b1;
        tick();
        chk("stall_sel_load", 32'(out_src), 32'd1);

        // RR wrap: ptr reaches 2, only channel 0 valid.
        mode = 1'b1; in_valid = 4'b0010;
        tick();
        chk("wrap_prep_src", 32'(out_src), 32'd1);
        in_valid = 4'b0001;
        tick();
        chk("wrap_src", 32'(out_src), 32'd0);
        in_valid = 4'b1111;
        #1 chk("wrap_ptr1_ready", 32'(in_ready), 32'h2);
        tick();
        chk("wrap_ptr1_src", 32'(out_src), 32'd1);

        in_valid = 4'b0000;
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-stream with a word buffered.
        in_valid = 4'b1111;
        tick();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_out_src", 32'(out_src), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        #1 chk("post_rst_ready", 32'(in_ready), 32'h1);
        tick();
        chk("post_rst_src", 32'(out_src), 32'd0);
        in_valid = 4'b0000;

        // N_IN = 3: out-of-range sel serves nothing; RR wraps 2 -> 0.
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
        in_data3[0] = 7'h01; in_data3[1] = 7'h02; in_data3[2] = 7'h03;
        #1 chk("n3_sel3_ready", 32'(in_ready3), 32'd0);
        tick();
        chk("n3_sel3_valid_a", 32'(out_valid3), 32'd0);
        tick();
        chk("n3_sel3_valid_b", 32'(out_valid3), 32'd0);
        mode3 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("n3_rr_src", 32'(out_src3), 32'(k % 3));
            chk("n3_rr_data", 32'(out_data3), 32'(k % 3 + 1));
        end

        tick();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
